// File: rtl/multi_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler and its datapath.
package multi_pkg;

  localparam int unsigned OP_W          = 4;
  localparam int unsigned RES_W         = 2 * OP_W;
  localparam int unsigned RES_START_DEF = 11;
  localparam int unsigned CNT_W         = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/multi_top.sv
// Bit-serial 4x4 multiplier datapath: operands arrive LSB-first after RST,
// product bit k appears on O at op cycle RES_START_DEF+k.
module multi_top
  import multi_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic A,
  input  logic B,
  output logic O
);

  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  a_buf;
  logic [OP_W-1:0]  b_buf;
  logic [RES_W-1:0] p;

  // Capture operand bits, then shift-add one partial product per cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      a_buf <= '0;
      b_buf <= '0;
      p     <= '0;
    end else begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
      if (cnt < CNT_W'(OP_W)) begin
        a_buf[cnt[1:0]] <= A;
        b_buf[cnt[1:0]] <= B;
      end
      if (cnt >= CNT_W'(OP_W) && cnt < CNT_W'(2 * OP_W) && b_buf[cnt[1:0]])
        p <= p + (RES_W'(a_buf) << cnt[1:0]);
    end
  end

  always_comb begin
    O = 1'b0;
    if (cnt >= CNT_W'(RES_START_DEF) && cnt < CNT_W'(RES_START_DEF + RES_W))
      O = p[3'(cnt - CNT_W'(RES_START_DEF))];
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       gnt_vld
);

  logic last;

  // On a tie, favour whoever was not served last.
  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ~last;
  end

  assign gnt_vld = |req;

  always_ff @(posedge clk) begin
    if (rst)          last <= 1'b1;
    else if (advance) last <= grant;
  end

endmodule

// File: rtl/multi_sched.sv
// Round-robin front end for the bit-serial multiplier: accepts operand pairs,
// streams them into the datapath and returns the tagged serial product.
module multi_sched
  import multi_pkg::*;
#(
  parameter int unsigned RES_START = RES_START_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  input  logic [2*OP_W-1:0] req_a,
  input  logic [2*OP_W-1:0] req_b,
  output logic [1:0]        req_ready,
  output logic              res_valid,
  output logic              res_id,
  output logic [RES_W-1:0]  res_p,
  output logic              busy,
  output logic              mul_rst,
  output logic              mul_a,
  output logic              mul_b,
  input  logic              mul_o
);

  localparam logic [CNT_W-1:0] T_FEED_END = CNT_W'(RES_START - 1);
  localparam logic [CNT_W-1:0] T_LAST     = CNT_W'(RES_START + RES_W - 1);

  state_t           state;
  logic [CNT_W-1:0] t;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic             id_q;
  logic [RES_W-1:0] prod;
  logic             grant;
  logic             gnt_vld;
  logic             advance;
  logic             driving;

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .gnt_vld (gnt_vld)
  );

  // Ready is a pure function of state and valid; never of the datapath.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !RST && gnt_vld) req_ready[grant] = req_valid[grant];
  end

  assign advance = |(req_valid & req_ready);
  assign driving = (state == FEED) || (state == COLLECT);
  assign mul_rst = RST || (state == CLR);
  assign mul_a   = driving && a_q[t[1:0]];
  assign mul_b   = driving && b_q[t[1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      t         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      prod      <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_p     <= '0;
      busy      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (advance) begin
            a_q   <= grant ? req_a[2*OP_W-1:OP_W] : req_a[OP_W-1:0];
            b_q   <= grant ? req_b[2*OP_W-1:OP_W] : req_b[OP_W-1:0];
            id_q  <= grant;
            busy  <= 1'b1;
            state <= CLR;
          end
        end
        CLR: begin
          t     <= '0;
          prod  <= '0;
          state <= FEED;
        end
        FEED: begin
          t <= t + CNT_W'(1);
          if (t == T_FEED_END) state <= COLLECT;
        end
        // Product arrives LSB-first; shift in from the top.
        COLLECT: begin
          prod <= {mul_o, prod[RES_W-1:1]};
          t    <= t + CNT_W'(1);
          if (t == T_LAST) begin
            res_p     <= {mul_o, prod[RES_W-1:1]};
            res_id    <= id_q;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_sched.sv
// Bench for multi_sched driving the bit-serial multiplier datapath.
module tb_multi_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_ready;
  logic       res_valid;
  logic       res_id;
  logic [7:0] res_p;
  logic       busy;
  logic       mul_rst;
  logic       mul_a;
  logic       mul_b;
  logic       mul_o;

  multi_sched dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy),
    .mul_rst   (mul_rst),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_o     (mul_o)
  );

  multi_top dp (
    .CLK (CLK),
    .RST (mul_rst),
    .A   (mul_a),
    .B   (mul_b),
    .O   (mul_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       id;
    logic [7:0] p;
    int         acc;
  } exp_t;

  typedef struct {
    logic [1:0] v;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    int         gnt;
    logic [7:0] p;
    bit         gap;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   clr_due  = -10;
  int   hs_count = 0;
  int   rv_count = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle protocol checks and result scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    check("ready_only_valid", int'(req_ready & ~req_valid), 0);
    check("ready_when_busy", busy ? int'(req_ready) : 0, 0);
    check("mul_rst", int'(mul_rst), int'(RST === 1'b1 || cyc == clr_due));
    if (RST !== 1'b1 && (req_valid & req_ready) != 2'b00) begin
      hs_count++;
      clr_due = cyc + 1;
    end
    if (res_valid === 1'b1) begin
      rv_count++;
      if (sb.size() == 0) begin
        check("unexpected_res_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("res_p", int'(res_p), int'(e.p));
        check("res_id", int'(res_id), int'(e.id));
        check("res_latency", cyc - e.acc, 21);
      end
    end
  end

  // Present a request (caller sits just after a posedge), wait for the accept.
  task automatic do_req(input logic [1:0] vmask, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1, input int exp_gnt,
                        input logic [7:0] exp_p, input bit push, input string tag,
                        output int acc);
    req_valid = vmask;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    acc       = -1;
    for (int i = 0; i < 60 && acc < 0; i++) begin
      @(negedge CLK);
      if ((req_valid & req_ready) != 2'b00) begin
        acc = cyc;
        check({tag, "_grant"}, int'(req_ready[1]), exp_gnt);
        check({tag, "_onehot"}, int'(req_ready == 2'b11), 0);
        if (push) sb.push_back(exp_t'{id: 1'(exp_gnt), p: exp_p, acc: acc});
      end
    end
    if (acc < 0) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge CLK);
    #2;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge CLK);
    #2;
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  initial begin
    int acc;
    int prev_acc;
    int hs0;
    int rv0;

    tbl[0] = '{v: 2'b01, a0: 4'd15, b0: 4'd15, a1: 4'd0, b1: 4'd0, gnt: 0, p: 8'd225, gap: 1'b0};
    tbl[1] = '{v: 2'b10, a0: 4'd0,  b0: 4'd0,  a1: 4'd3, b1: 4'd5, gnt: 1, p: 8'd15,  gap: 1'b0};
    tbl[2] = '{v: 2'b11, a0: 4'd2,  b0: 4'd7,  a1: 4'd9, b1: 4'd4, gnt: 0, p: 8'd14,  gap: 1'b1};
    tbl[3] = '{v: 2'b11, a0: 4'd2,  b0: 4'd7,  a1: 4'd9, b1: 4'd4, gnt: 1, p: 8'd36,  gap: 1'b1};
    tbl[4] = '{v: 2'b11, a0: 4'd2,  b0: 4'd7,  a1: 4'd9, b1: 4'd4, gnt: 0, p: 8'd14,  gap: 1'b1};
    tbl[5] = '{v: 2'b11, a0: 4'd2,  b0: 4'd7,  a1: 4'd9, b1: 4'd4, gnt: 1, p: 8'd36,  gap: 1'b1};
    tbl[6] = '{v: 2'b01, a0: 4'd0,  b0: 4'd13, a1: 4'd0, b1: 4'd0, gnt: 0, p: 8'd0,   gap: 1'b0};
    tbl[7] = '{v: 2'b01, a0: 4'd1,  b0: 4'd1,  a1: 4'd0, b1: 4'd0, gnt: 0, p: 8'd1,   gap: 1'b0};

    RST       = 1'b1;
    req_valid = 2'b00;
    req_a     = 8'h00;
    req_b     = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_id", int'(res_id), 0);
    check("rst_res_p", int'(res_p), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mul_ab", int'({mul_a, mul_b}), 0);
    check("rst_mul_rst", int'(mul_rst), 1);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_mul_rst", int'(mul_rst), 0);
    @(posedge CLK);
    #2;

    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].gnt, tbl[i].p,
             1'b1, $sformatf("vec%0d", i), acc);
      if (tbl[i].gap) check($sformatf("vec%0d_spacing", i), acc - prev_acc, 22);
      prev_acc = acc;
    end
    req_valid = 2'b00;
    drain("table");

    // Reset lands at op cycle t=8; the product must be discarded.
    @(posedge CLK);
    #2;
    do_req(2'b01, 4'd6, 4'd6, 4'd0, 4'd0, 0, 8'd36, 1'b0, "rstmid", acc);
    req_valid = 2'b00;
    repeat (9) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    rv0 = rv_count;
    @(negedge CLK);
    check("rstmid_busy", int'(busy), 0);
    repeat (25) @(posedge CLK);
    #2;
    check("rstmid_no_result", rv_count - rv0, 0);
    do_req(2'b10, 4'd0, 4'd0, 4'd10, 4'd10, 1, 8'd100, 1'b1, "after_rst", acc);
    do_req(2'b11, 4'd5, 4'd5, 4'd10, 4'd10, 0, 8'd25, 1'b1, "after_rst_tie", acc);
    req_valid = 2'b00;
    drain("rstmid");

    // Requester 1 withdraws while busy; requester 0 carries on.
    @(posedge CLK);
    #2;
    do_req(2'b01, 4'd4, 4'd3, 4'd0, 4'd0, 0, 8'd12, 1'b1, "drop_first", prev_acc);
    hs0       = hs_count;
    req_valid = 2'b10;
    req_a     = {4'd7, 4'd0};
    req_b     = {4'd7, 4'd0};
    repeat (6) @(posedge CLK);
    #2;
    req_valid = 2'b00;
    repeat (4) @(posedge CLK);
    #2;
    do_req(2'b01, 4'd2, 4'd2, 4'd7, 4'd7, 0, 8'd4, 1'b1, "drop_next", acc);
    req_valid = 2'b00;
    check("drop_handshakes", hs_count - hs0, 1);
    check("drop_spacing", acc - prev_acc, 22);
    drain("drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_sched.md
# multi_sched

Two-requester round-robin scheduler in front of the bit-serial 4x4 multiplier datapath (`multi_top`). It accepts parallel 4-bit operand pairs over valid/ready handshakes and clears the datapath before each operation. It streams the operands LSB-first into the datapath and captures the serial 8-bit product. It then returns the product to the granted requester, tagged with that requester's id.

## Interface
- `OP_W`, 4: operand width. Fixed by the datapath; do not override.
- `RES_W`, 8: product width, 2*OP_W.
- `RES_START`, 11: op cycle at which product bit 0 appears on `mul_o`.
- `CLK`  in  1: sole clock; all logic on posedge.
- `RST`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: per-requester request.
- `req_a`  in  2*OP_W: operand A; requester i occupies bits [i*4+:4].
- `req_b`  in  2*OP_W: operand B; same packing as `req_a`.
- `req_ready`  out  2: per-requester accept. Transfer occurs when valid and ready are both high.
- `res_valid`  out  1: one-cycle result strobe. No backpressure.
- `res_id`  out  1: requester that owns the result.
- `res_p`  out  RES_W: unsigned product.
- `busy`  out  1: high in any state except IDLE.
- `mul_rst`  out  1: drives the datapath `RST`.
- `mul_a`, `mul_b`  out  1: drive the datapath `A`/`B`.
- `mul_o`  in  1: datapath `O`.

## Operation
- States: IDLE, CLR, FEED, COLLECT, DONE.
- IDLE:
  - Arbiter picks `grant`; `req_ready[grant]` = `req_valid[grant]`; the other ready bit is 0.
  - On transfer: latch A, B and id; update the round-robin pointer to the granted requester; go to CLR.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that was not granted last.
  - Pointer after reset: last = 1, so requester 0 wins the first tie.
- CLR: `mul_rst`=1 for exactly one cycle; go to FEED with op counter t=0.
- FEED (t = 0..RES_START-1):
  - `mul_a` = A[t mod 4], `mul_b` = B[t mod 4].
  - Operands are re-driven cyclically so the datapath operand buffers stay constant.
- COLLECT (t = RES_START..RES_START+7):
  - Keep driving operands cyclically.
  - Sample `mul_o` into product bit (t-RES_START), LSB first.
  - After the t=RES_START+7 sample, go to DONE.
- DONE:
  - `res_valid`=1; `res_p` = captured product; `res_id` = latched id.
  - Go to IDLE.
  - `res_p`/`res_id` hold their values until the next DONE.
- `mul_rst` = RST | (state==CLR).
- `mul_a`/`mul_b` = 0 in IDLE, CLR and DONE.
- Arithmetic: unsigned, 15*15=225 fits RES_W. The product is never computed locally; it comes only from `mul_o`.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_id`=0, `res_p`=0, `busy`=0, `mul_a`=`mul_b`=0, `mul_rst`=1 while RST is high. State is IDLE and the pointer is last=1.
- Accept in cycle n:
  - CLR in n+1.
  - Op cycle t=0 in n+2.
  - Last sample at n+RES_START+9 (n+20 with default).
  - `res_valid` in n+21.
  - Next accept no earlier than n+22.
- Throughput: one operation per 22 cycles.
- Requesters must hold `req_valid` and operands stable until accepted. A request that arrives during `busy` waits.
- Simultaneous valid in IDLE: exactly one ready bit is high, never both.
- RST mid-operation: the next cycle is IDLE and the captured product is discarded. No `res_valid` is issued, and the pointer returns to last=1.
- `req_ready` depends combinationally on `req_valid` and state only. There is no path from `mul_o` to `req_ready`.

## Structure
- Package `multi_pkg` holds:
  - state enum {IDLE, CLR, FEED, COLLECT, DONE};
  - `OP_W`=4, `RES_W`=8, `RES_START_DEF`=11;
  - the op counter width (5 bits, covering 0..RES_START+7).
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `advance`.
  - Outputs: `grant`, `gnt_vld`.
  - The pointer updates only on `advance` (the transfer). Synchronous reset is shared with the parent.
- The bench instantiates `multi_sched` connected to a real `multi_top`.

## Test plan
- Single request, requester 0, A=15, B=15: `res_valid` 21 cycles after accept with `res_p`=225 and `res_id`=0. `mul_rst` high exactly one cycle, at accept+1.
- Requester 1 only, A=3, B=5: `res_p`=15, `res_id`=1, `req_ready[0]` stays 0.
- Both valid continuously, requester 0 with A=2, B=7 and requester 1 with A=9, B=4: grants alternate 0,1,0,1, results alternate 14, 36, and accepts are spaced 22 cycles apart.
- Zero operands, A=0, B=13: `res_p`=0. Then A=1, B=1: `res_p`=1. This checks that no stale bits leak between operations.
- RST asserted at t=8 of an operation (A=6, B=6): no `res_valid`. The next request (requester 1, A=10, B=10) returns 100 with `res_id`=1, and the next tie grants requester 0.
- Requester drops `req_valid` before it is accepted (while `busy`): no transfer occurs and the other requester proceeds normally.
